// File: rtl/job_engine_pkg.sv
// Shared types and default sizing for the job_engine worker datapath.
// Optional parity checking is enabled by defining JOB_ENGINE_PARITY_EN.
package job_engine_pkg;

    localparam int LEN_W_DEF   = 8;
    localparam int DATA_W_DEF  = 8;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        FINISH,
        FAIL
    } state_t;

endpackage

// File: rtl/job_engine_stall_timer.sv
// Stall counter for job_engine: clear/increment with an expiry flag
// raised on the increment that brings the count up to TIMEOUT.
module stall_timer
    import job_engine_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // expiry is combinational so the FSM leaves on the TIMEOUT-th stall
    assign expired = inc && (count_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != CNT_W'(TIMEOUT))) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/job_engine.sv
// Worker datapath behind the run/done/error handshake: streams job_len
// beats into a checksum. Define JOB_ENGINE_PARITY_EN for in_parity checks.
module job_engine
    import job_engine_pkg::*;
#(
    parameter int LEN_W   = LEN_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              busy,
    input  logic [LEN_W-1:0]  job_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
`ifdef JOB_ENGINE_PARITY_EN
    input  logic              in_parity,
`endif
    output logic              in_ready,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] checksum,
    output logic [LEN_W-1:0]  beat_cnt
);

    state_t            state_q, state_d;
    logic              busy_q;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;

    logic start;
    logic parity_ok;
    logic st_clr;
    logic st_inc;
    logic st_expired;

    assign start = busy & ~busy_q;

`ifdef JOB_ENGINE_PARITY_EN
    assign parity_ok = (in_parity == ^in_data);
`else
    assign parity_ok = 1'b1;
`endif

    stall_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (8)
    ) u_stall (
        .clk     (clk),
        .reset   (reset),
        .clr     (st_clr),
        .inc     (st_inc),
        .expired (st_expired)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        beat_cnt_d  = beat_cnt_q;
        checksum_d  = checksum_q;
        in_ready    = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        st_clr      = 1'b0;
        st_inc      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    checksum_d = '0;
                    beat_cnt_d = '0;
                    st_clr     = 1'b1;
                end
            end
            LOAD: begin
                remaining_d = job_len;
                if (!busy) begin
                    state_d = IDLE;
                end else if (job_len == '0) begin
                    state_d = FAIL;
                end else begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                in_ready = 1'b1;
                // an abort drops any beat offered in the same cycle
                if (!busy) begin
                    state_d = IDLE;
                end else if (in_valid) begin
                    st_clr = 1'b1;
                    if (!parity_ok) begin
                        state_d = FAIL;
                    end else begin
                        checksum_d  = checksum_q + in_data;
                        beat_cnt_d  = beat_cnt_q + 1'b1;
                        remaining_d = remaining_q - 1'b1;
                        if (remaining_q == LEN_W'(1)) begin
                            state_d = FINISH;
                        end
                    end
                end else begin
                    st_inc = 1'b1;
                    if (st_expired) begin
                        state_d = FAIL;
                    end
                end
            end
            FINISH: begin
                done = 1'b1;
                if (!busy) begin
                    state_d = IDLE;
                end
            end
            FAIL: begin
                error = 1'b1;
                if (!busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            remaining_q <= '0;
            beat_cnt_q  <= '0;
            checksum_q  <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy;
            remaining_q <= remaining_d;
            beat_cnt_q  <= beat_cnt_d;
            checksum_q  <= checksum_d;
        end
    end

    assign checksum = checksum_q;
    assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_job_engine.sv
// Scoreboard bench for job_engine: randomized jobs against a beat/gap model.
// Parity cases are exercised when JOB_ENGINE_PARITY_EN is defined.
module tb_job_engine;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       busy;
    logic [7:0] job_len;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_parity;
    logic       in_ready;
    logic       done;
    logic       error;
    logic [7:0] checksum;
    logic [7:0] beat_cnt;

    job_engine #(
        .LEN_W   (8),
        .DATA_W  (8),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .busy      (busy),
        .job_len   (job_len),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef JOB_ENGINE_PARITY_EN
        .in_parity (in_parity),
`endif
        .in_ready  (in_ready),
        .done      (done),
        .error     (error),
        .checksum  (checksum),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rdy_cnt = 0;
    always @(negedge clk) if (in_ready === 1'b1) rdy_cnt <= rdy_cnt + 1;

    typedef struct {
        bit         is_err;
        int         cyc;
        logic [7:0] sum;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];

    int n_tests = 0;
    int n_fail  = 0;

    int         g_gap[16];
    logic [7:0] g_dat[16];
    bit         g_bad[16];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Monitor: every rising done/error retires one expected job outcome
    exp_t e;
    logic done_p = 1'b0;
    logic err_p  = 1'b0;
    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            done_p <= 1'b0;
            err_p  <= 1'b0;
        end else begin
            if ((done && !done_p) || (error && !err_p)) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: done=%0d error=%0d %s",
                             done, error, "with no job outstanding");
                end else begin
                    e = q.pop_front();
                    chk("out_cycle", cyc, e.cyc);
                    chk("done", {31'b0, done}, {31'b0, !e.is_err});
                    chk("error", {31'b0, error}, {31'b0, e.is_err});
                    chk("checksum", {24'b0, checksum}, {24'b0, e.sum});
                    chk("beat_cnt", {24'b0, beat_cnt}, {24'b0, e.cnt});
                    chk("ready_off", {31'b0, in_ready}, 32'd0);
                end
            end
            done_p <= done;
            err_p  <= error;
        end
    end

    task automatic clr_plan();
        for (int i = 0; i < 16; i++) begin
            g_gap[i] = 0;
            g_dat[i] = 8'($urandom);
            g_bad[i] = 1'b0;
        end
    endtask

    // mode 0: full job, 1: busy drop after k beats, 2: reset after k beats
    task automatic run_job(input int len, input int mode, input int k);
        int         s;
        int         last;
        int         end_c;
        int         nb;
        int         hold;
        bit         fin;
        bit         is_err;
        logic [7:0] sum;
        logic [7:0] cnt;
        logic [7:0] asum;
        logic [7:0] acnt;
        exp_t       x;
        @(negedge clk);
        busy     = 1'b1;
        job_len  = 8'(len);
        in_valid = 1'b0;
        s        = cyc + 1;
        sum      = 8'd0;
        cnt      = 8'd0;
        last     = s + 1;
        fin      = 1'b0;
        is_err   = 1'b0;
        end_c    = 0;
        if (len == 0) begin
            fin    = 1'b1;
            is_err = 1'b1;
            end_c  = s + 1;
        end
        for (int i = 0; i < len && !fin; i++) begin
            if (g_gap[i] >= TO) begin
                fin    = 1'b1;
                is_err = 1'b1;
                end_c  = last + TO;
            end else begin
                last = last + g_gap[i] + 1;
                if (g_bad[i]) begin
                    fin    = 1'b1;
                    is_err = 1'b1;
                    end_c  = last;
                end else begin
                    sum = sum + g_dat[i];
                    cnt = cnt + 8'd1;
                    if (int'(cnt) == len) begin
                        fin   = 1'b1;
                        end_c = last;
                    end
                end
            end
        end
        if (mode == 0) begin
            x.is_err = is_err;
            x.cyc    = end_c;
            x.sum    = sum;
            x.cnt    = cnt;
            q.push_back(x);
        end
        nb   = (mode == 0) ? len : k;
        asum = 8'd0;
        acnt = 8'd0;
        @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            for (int g = 0; g < g_gap[i]; g++) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end
            @(negedge clk);
            in_valid  = 1'b1;
            in_data   = g_dat[i];
            in_parity = (^g_dat[i]) ^ g_bad[i];
            asum      = asum + g_dat[i];
            acnt      = acnt + 8'd1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (mode == 0) begin
            hold = $urandom_range(0, 3);
            while (cyc < end_c + 1 + hold) @(negedge clk);
            busy = 1'b0;
            @(negedge clk);
            chk("drop_done", {31'b0, done}, 32'd0);
            chk("drop_error", {31'b0, error}, 32'd0);
            chk("held_sum", {24'b0, checksum}, {24'b0, sum});
            chk("held_cnt", {24'b0, beat_cnt}, {24'b0, cnt});
        end else if (mode == 1) begin
            busy = 1'b0;
            @(negedge clk);
            chk("abort_ready", {31'b0, in_ready}, 32'd0);
            chk("abort_done", {31'b0, done}, 32'd0);
            chk("abort_error", {31'b0, error}, 32'd0);
            chk("abort_cnt", {24'b0, beat_cnt}, {24'b0, acnt});
            chk("abort_sum", {24'b0, checksum}, {24'b0, asum});
        end else begin
            busy  = 1'b0;
            reset = 1'b1;
            @(negedge clk);
            chk("rst_ready", {31'b0, in_ready}, 32'd0);
            chk("rst_done", {31'b0, done}, 32'd0);
            chk("rst_error", {31'b0, error}, 32'd0);
            chk("rst_cnt", {24'b0, beat_cnt}, 32'd0);
            chk("rst_sum", {24'b0, checksum}, 32'd0);
            reset = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int mode;
        int k;
        int r;
        int r0;
        reset     = 1'b1;
        busy      = 1'b0;
        job_len   = 8'd0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        in_parity = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ready", {31'b0, in_ready}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_error", {31'b0, error}, 32'd0);
        chk("reset_sum", {24'b0, checksum}, 32'd0);
        chk("reset_cnt", {24'b0, beat_cnt}, 32'd0);
        reset = 1'b0;

        clr_plan();
        run_job(5, 2, 2);
        clr_plan();
        run_job(5, 0, 0);

        clr_plan();
        g_dat[0] = 8'h10;
        g_dat[1] = 8'h20;
        g_dat[2] = 8'h30;
        g_dat[3] = 8'hF0;
        run_job(4, 0, 0);

        clr_plan();
        g_gap[1] = 16;
        run_job(3, 0, 0);

        clr_plan();
        r0 = rdy_cnt;
        run_job(0, 0, 0);
        chk("len0_ready", rdy_cnt - r0, 32'd0);

        clr_plan();
        run_job(6, 1, 2);

        clr_plan();
        g_gap[0] = 15;
        g_gap[1] = 15;
        run_job(2, 0, 0);

        clr_plan();
        g_gap[0] = 16;
        run_job(2, 0, 0);

`ifdef JOB_ENGINE_PARITY_EN
        clr_plan();
        g_dat[0] = 8'h37;
        g_dat[1] = 8'h01;
        g_bad[1] = 1'b1;
        run_job(2, 0, 0);
`endif

        for (int j = 0; j < 40; j++) begin
            clr_plan();
            len  = $urandom_range(0, 8);
            mode = 0;
            k    = 0;
            if (len >= 2 && $urandom_range(0, 7) == 0) begin
                mode = 1;
                k    = $urandom_range(1, len - 1);
            end
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 19);
                g_gap[i] = (r < 14) ? (r % 4) : r;
                if (mode == 1 && g_gap[i] >= TO) g_gap[i] = 2;
`ifdef JOB_ENGINE_PARITY_EN
                if (mode == 0 && $urandom_range(0, 9) == 0) g_bad[i] = 1'b1;
`endif
            end
            run_job(len, mode, k);
        end

        repeat (5) @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
